// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider behind a start/busy/done handshake.
// Optional macro SIGNED_MULDIV_EN adds two's-complement operation through an extra FIX cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SIGNED_MULDIV_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    localparam state_t S_LAST_NEXT = S_FIX;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    localparam state_t S_LAST_NEXT = S_DONE;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic               dz_q, dz_d;
`ifdef SIGNED_MULDIV_EN
    logic               mul_q, mul_d, neg_q, neg_d, rneg_q, rneg_d;
    logic [2*WIDTH-1:0] prod;
`else
    logic               unused_sgn;
    assign unused_sgn = sgn;
`endif

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_sh, step;
    logic [WIDTH-1:0]   xm, ym;
    logic               last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dz_d    = dz_q;
`ifdef SIGNED_MULDIV_EN
        mul_d   = mul_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        prod    = acc_q;
`endif
        xm      = x;
        ym      = y;
        step    = acc_q;
        last    = (cnt_q == CW'(WIDTH - 1));

        // acc holds {hi, multiplier} for MUL and {rem, quo} for DIV
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {acc_q[2*WIDTH-2:0], 1'b0};
        // keep the bit shifted out of rem so the trial subtract sees WIDTH+1 bits
        div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, a_q};

        case (state_q)
            S_IDLE: begin
`ifdef SIGNED_MULDIV_EN
                if (sgn && x[WIDTH-1]) xm = -x;
                if (sgn && y[WIDTH-1]) ym = -y;
                neg_d  = sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
                rneg_d = sgn & x[WIDTH-1];
                mul_d  = (op == 4'd3);
`endif
                if (start && op == 4'd3) begin
                    acc_d   = {{WIDTH{1'b0}}, ym};
                    a_d     = xm;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_MUL;
                end else if (start && op == 4'd4) begin
                    cnt_d = '0;
                    if (y == '0) begin
                        lo_d    = '1;
                        hi_d    = x;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, xm};
                        a_d     = ym;
                        dz_d    = 1'b0;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    step = {mul_sum, acc_q[WIDTH-1:1]};
                end else if (div_diff[WIDTH+1]) begin
                    step = div_sh;
                end else begin
                    step = {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
                end
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_LAST_NEXT;
`ifndef SIGNED_MULDIV_EN
                    lo_d = step[WIDTH-1:0];
                    hi_d = step[2*WIDTH-1:WIDTH];
`endif
                end
            end
`ifdef SIGNED_MULDIV_EN
            S_FIX: begin
                if (mul_q) begin
                    prod = neg_q ? -acc_q : acc_q;
                    lo_d = prod[WIDTH-1:0];
                    hi_d = prod[2*WIDTH-1:WIDTH];
                end else begin
                    lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        acc_q <= acc_d;
`ifdef SIGNED_MULDIV_EN
        mul_q  <= mul_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
`endif
    end

`ifdef SIGNED_MULDIV_EN
    assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
`else
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`endif
    assign done      = (state_q == S_DONE);
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed operations push expected results,
// a monitor pops and compares them whenever done pulses.
module tb_muldiv_sequencer;
    localparam int W = 32;
`ifdef SIGNED_MULDIV_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic         sgn = 1'b0;
    logic [W-1:0] x = '0, y = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] result_lo, result_hi;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
        .x(x), .y(y), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_lo", 64'(result_lo), 64'(e.lo));
                check("result_hi", 64'(result_hi), 64'(e.hi));
                check("div_zero", 64'(div_zero), 64'(e.dz));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input logic s, input bit push, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input logic edz, input logic ebusy);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; x = xa; y = ya; sgn = s;
        if (push) begin
            e.lo = elo; e.hi = ehi; e.dz = edz;
            e.cyc = cyc + (edz ? 1 : LAT);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", 64'(busy), 64'(ebusy));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lo", 64'(result_lo), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;

        issue(4'd3, 32'hFFFF_FFFF, 32'h2, 1'b0, 1, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b1);
        wait_done("mul_ff_x2");
        issue(4'd4, 32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_done("div_100_7");
        // back-to-back starts in the cycle after done
        issue(4'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        wait_done("div_ff_1");
        issue(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);
        wait_done("mul_ff_ff");
        issue(4'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        wait_done("div_fe_ff");
        issue(4'd4, 32'h8000_0000, 32'd3, 1'b0, 1, 32'h2AAA_AAAA, 32'd2, 1'b0, 1'b1);
        wait_done("div_8_3");
        issue(4'd4, 32'd7, 32'd100, 1'b0, 1, 32'd0, 32'd7, 1'b0, 1'b1);
        wait_done("div_7_100");

        // second start while busy is dropped
        issue(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b0, 1, 32'd0, 32'd1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        issue(4'd4, 32'd9, 32'd3, 1'b0, 0, '0, '0, 1'b0, 1'b1);
        wait_done("mul_busy_start");
        // start presented during the DONE cycle is dropped
        start = 1'b1; op = 4'd3; x = 32'd5; y = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done_start", 64'(busy), 64'd0);
        @(negedge clk);
        check("busy_after_done_start2", 64'(busy), 64'd0);

        // unsupported op code
        issue(4'd5, 32'd3, 32'd4, 1'b0, 0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("op5_busy", 64'(busy), 64'd0);

        // divide by zero: done in cycle 1, flag held afterwards
        issue(4'd4, 32'h1234_5678, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("dz_held", 64'(div_zero), 64'd1);
        check("dz_lo_held", 64'(result_lo), 64'hFFFF_FFFF);

        // reset in cycle 10 of a multiply
        issue(4'd3, 32'd3, 32'd5, 1'b0, 1, 32'd15, 32'd0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_lo", 64'(result_lo), 64'd0);
        check("midrst_hi", 64'(result_hi), 64'd0);
        check("midrst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd3, 32'd6, 32'd7, 1'b0, 1, 32'd42, 32'd0, 1'b0, 1'b1);
        wait_done("mul_after_rst");

`ifdef SIGNED_MULDIV_EN
        issue(4'd3, 32'hFFFF_FFF9, 32'd3, 1'b1, 1, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("smul_m7_3");
        issue(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("sdiv_m7_2");
        issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        wait_done("sdiv_ovf");
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
